// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, control states and the iteration counter width.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  // Counter must hold 0..width so a full run of width iterations fits.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mdu_abs.sv
// Magnitude and sign extraction for one operand; a signed operand is
// negated to its magnitude, an unsigned operand passes through unchanged.
module mdu_abs #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             sign
);

  // Two's-complement negate when the operand is signed and negative.
  always_comb begin
    sign = is_signed & value[WIDTH-1];
    mag  = sign ? ('0 - value) : value;
  end

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// One result bit per RUN cycle over operand magnitudes, signs restored in FIX.
// Optional build macro MDU_EARLY_OUT_EN: multiplication leaves RUN once the
// remaining multiplier bits are all zero (minimum one RUN cycle).
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t state, state_next;

  logic               is_div_q;
  logic               neg_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   y;
  logic [CNT_W-1:0]   cnt;

  logic               op_is_div;
  logic               op_is_signed;
  logic               dz_start;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sign_a, sign_b;
  logic               last_iter;
  logic               early_exit;
  logic               done_next;
  logic               dz_next;

  logic [2*WIDTH-1:0] mult_acc_next;
  logic [WIDTH:0]     div_shifted;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign op_is_div    = (op == OP_DIV) || (op == OP_DIVU);
  assign op_is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign dz_start     = start && op_is_div && (b == '0);

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value     (a),
    .is_signed (op_is_signed),
    .mag       (mag_a),
    .sign      (sign_a)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value     (b),
    .is_signed (op_is_signed),
    .mag       (mag_b),
    .sign      (sign_b)
  );

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

`ifdef MDU_EARLY_OUT_EN
  // After this iteration only y[WIDTH-1:1] remains to be consumed.
  assign early_exit = !is_div_q && (y[WIDTH-1:1] == '0);
`else
  assign early_exit = 1'b0;
`endif

  // One iteration of shift-add multiply and restoring divide, plus the FIX-stage sign restore.
  always_comb begin
    mult_acc_next = y[0] ? (acc + mcand) : acc;
    div_shifted   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_ge        = (div_shifted >= {1'b0, y});
    div_rem_next  = div_ge ? (div_shifted[WIDTH-1:0] - y) : div_shifted[WIDTH-1:0];
    prod_fixed    = neg_q ? ('0 - acc) : acc;
    if (is_div_q) begin
      res_lo = neg_q     ? ('0 - acc[WIDTH-1:0])       : acc[WIDTH-1:0];
      res_hi = neg_rem_q ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod_fixed[WIDTH-1:0];
      res_hi = prod_fixed[2*WIDTH-1:WIDTH];
    end
  end

  // Next-state and handshake decode; a zero divisor completes straight from IDLE.
  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    dz_next    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (dz_start) begin
            done_next = 1'b1;
            dz_next   = 1'b1;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else if (last_iter || early_exit) begin
          state_next = ST_FIX;
        end
      end
      ST_FIX: begin
        state_next = ST_IDLE;
        done_next  = !cancel;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State, handshake outputs, HI/LO and the iteration datapath.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      y         <= '0;
      cnt       <= '0;
    end else begin
      state    <= state_next;
      busy     <= (state_next != ST_IDLE);
      done     <= done_next;
      div_zero <= dz_next;

      if (!busy && hi_we) hi <= wdata;
      if (!busy && lo_we) lo <= wdata;

      case (state)
        ST_IDLE: begin
          if (start && !dz_start) begin
            is_div_q  <= op_is_div;
            neg_q     <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
            cnt       <= '0;
            y         <= mag_b;
            mcand     <= {{WIDTH{1'b0}}, mag_a};
            // Divide keeps {remainder, dividend/quotient} in acc; multiply starts from zero.
            acc       <= op_is_div ? {{WIDTH{1'b0}}, mag_a} : '0;
          end
        end
        ST_RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (is_div_q) begin
            acc <= {div_rem_next, acc[WIDTH-2:0], div_ge};
          end else begin
            acc   <= mult_acc_next;
            mcand <= mcand << 1;
            y     <= y >> 1;
          end
        end
        ST_FIX: begin
          if (!cancel) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32): a transaction-level
// reference model checked every cycle, plus directed literal scenarios.
module tb_mdu_iterative;

  localparam int unsigned W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op    = 2'd0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          cancel = 1'b0;
  logic          hi_we = 1'b0;
  logic          lo_we = 1'b0;
  logic [W-1:0]  wdata = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  mdu_iterative #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .cancel   (cancel),
    .hi_we    (hi_we),
    .lo_we    (lo_we),
    .wdata    (wdata),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic         m_busy = 1'b0, m_done = 1'b0, m_dz = 1'b0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int           m_left = 0;
  logic         nd, nz;

  function automatic void compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] yv,
                                  output logic [W-1:0] rh, output logic [W-1:0] rl);
    longint     sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(yv));
    case (o)
      2'd0: p = sx * sy;
      2'd1: p = {32'b0, x} * {32'b0, yv};
      2'd2: begin
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
      end
      default: p = {x % yv, x / yv};
    endcase
    rh = p[63:32];
    rl = p[31:0];
  endfunction

  // Number of cycles busy stays high for an accepted operation.
  function automatic int busy_cycles(input logic [1:0] o, input logic [W-1:0] yv);
    logic [W-1:0] m;
    int k;
    m = (o == 2'd0 && yv[W-1]) ? ('0 - yv) : yv;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
`ifdef MDU_EARLY_OUT_EN
    if (!o[1]) return k + 1;
`endif
    return (k > 0) ? W + 1 : W + 1;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0;
      m_hi = '0; m_lo = '0; m_left = 0;
    end else begin
      nd = 1'b0;
      nz = 1'b0;
      if (!m_busy) begin
        if (hi_we) m_hi = wdata;
        if (lo_we) m_lo = wdata;
      end
      if (m_busy) begin
        if (cancel) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            nd = 1'b1;
            m_hi = p_hi;
            m_lo = p_lo;
          end
        end
      end else if (start) begin
        if (op[1] && b == '0) begin
          nd = 1'b1;
          nz = 1'b1;
        end else begin
          compute(op, a, b, p_hi, p_lo);
          m_left = busy_cycles(op, b);
          m_busy = 1'b1;
        end
      end
      m_done = nd;
      m_dz   = nz;
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      check("cyc_busy", W'(busy), W'(m_busy));
      check("cyc_done", W'(done), W'(m_done));
      check("cyc_div_zero", W'(div_zero), W'(m_dz));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; cancel = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] yv);
    op = o; a = x; b = yv; start = 1'b1;
  endtask

  // Starts in the current cycle (cycle 0); returns the cycle done rose, or -1.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] yv,
                        output int n);
    launch(o, x, yv);
    n = -1;
    for (int c = 1; c <= 100; c++) begin
      tick();
      idle_inputs();
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
    if (n < 0) $display("FAIL run_op_timeout: got no done expected done within 100 cycles");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'd1;
      4: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int n;
  logic saw_done;

  initial begin
    tick();
    tick();
    chk_en = 1'b1;
    reset = 1'b0;
    check("reset_busy", W'(busy), '0);
    check("reset_hi", hi, '0);
    check("reset_lo", lo, '0);

    // MULT -3 * 7, with busy pinned at the run boundaries
    tick();
    launch(2'd0, 32'hFFFF_FFFD, 32'd7);
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      idle_inputs();
      if (c == 1)  check("t1_busy_c1", W'(busy), 32'd1);
      if (c == 33) check("t1_busy_c33", W'(busy), 32'd1);
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
    check("t1_done_cycle", n, 32'd34);
    check("t1_busy_at_done", W'(busy), '0);
    check("t1_hi", hi, 32'hFFFF_FFFF);
    check("t1_lo", lo, 32'hFFFF_FFEB);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    check("t2_hi", hi, 32'hFFFF_FFFE);
    check("t2_lo", lo, 32'h0000_0001);

    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, n);
    check("t3a_lo", lo, 32'hFFFF_FFFD);
    check("t3a_hi", hi, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, n);
    check("t3b_lo", lo, 32'h8000_0000);
    check("t3b_hi", hi, 32'h0000_0000);
    check("t3b_dz", W'(div_zero), '0);

    // Preload HI/LO, then DIVU by zero
    hi_we = 1'b1; wdata = 32'h11;
    tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22;
    tick();
    idle_inputs();
    launch(2'd3, 32'd100, 32'd0);
    tick();
    idle_inputs();
    check("t4_done_c1", W'(done), 32'd1);
    check("t4_dz_c1", W'(div_zero), 32'd1);
    check("t4_busy_c1", W'(busy), '0);
    check("t4_hi", hi, 32'h11);
    check("t4_lo", lo, 32'h22);
    tick();
    check("t4_dz_c2", W'(div_zero), '0);
    check("t4_busy_c2", W'(busy), '0);

    // MULTU cancelled at cycle 10, restarted at cycle 12
    launch(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    saw_done = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      idle_inputs();
      if (done === 1'b1) saw_done = 1'b1;
      if (c == 10) cancel = 1'b1;
      if (c == 11) begin
        check("t5_busy_c11", W'(busy), '0);
        check("t5_hi_kept", hi, 32'h11);
        check("t5_lo_kept", lo, 32'h22);
      end
      if (c == 12) launch(2'd1, 32'h0001_0000, 32'h0003_0000);
    end
    check("t5_no_done", W'(saw_done), '0);
    n = -1;
    for (int c = 13; c <= 80; c++) begin
      tick();
      idle_inputs();
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
    check("t5_restart_done", n, 32'd46);
    check("t5_hi", hi, 32'd3);
    check("t5_lo", lo, 32'd0);

    // Reset at cycle 5 of a DIV
    launch(2'd2, 32'd1000, 32'd7);
    for (int c = 1; c <= 5; c++) begin
      tick();
      idle_inputs();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_hi", hi, '0);
    check("t6_lo", lo, '0);
    check("t6_busy", W'(busy), '0);
    check("t6_done", W'(done), '0);

    // lo_we while busy ignored; start at cycle 20 ignored
    launch(2'd0, 32'hFFFF_FFFE, 32'd5);
    n = -1;
    for (int c = 1; c <= 60; c++) begin
      tick();
      idle_inputs();
      if (c == 3) begin lo_we = 1'b1; wdata = 32'hDEAD; end
      if (c == 4) check("t7_lo_we_busy", lo, '0);
      if (c == 20) launch(2'd3, 32'd1, 32'd0);
      if (c == 21) check("t7_start_ignored", W'(done), '0);
      if (done === 1'b1) begin
        n = c;
        break;
      end
    end
    check("t7_done_cycle", n, 32'd34);
    check("t7_hi", hi, 32'hFFFF_FFFF);
    check("t7_lo", lo, 32'hFFFF_FFF6);

    // Random traffic against the model
    for (int i = 0; i < 6000; i++) begin
      tick();
      start  = ($urandom_range(0, 99) < 25);
      op     = 2'($urandom_range(0, 3));
      a      = pick();
      b      = pick();
      cancel = ($urandom_range(0, 99) < 3);
      hi_we  = ($urandom_range(0, 99) < 4);
      lo_we  = ($urandom_range(0, 99) < 4);
      wdata  = $urandom;
      reset  = ($urandom_range(0, 999) == 0);
    end
    tick();
    idle_inputs();
    reset = 1'b0;
    repeat (40) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
